// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings, FSM states, timeout default.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_lsu_align.sv
// Combinational byte-lane steering: store strobes/data replication, load extraction/extension,
// and the alignment / illegal-encoding check.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_sh_o,
    output logic [31:0] rdata_fmt_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, data formatting and fault detection
    always_comb begin
        wstrb_o     = 4'b0000;
        wdata_sh_o  = wdata_i;
        rdata_fmt_o = 32'h0000_0000;
        misalign_o  = 1'b0;
        byte_s      = 8'h00;
        half_s      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase

        case (funct3_i)
            F3_B: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_sh_o  = {4{wdata_i[7:0]}};
                rdata_fmt_o = {{24{byte_s[7]}}, byte_s};
            end
            F3_H: begin
                wstrb_o     = 4'b0011 << addr_lo_i;
                wdata_sh_o  = {2{wdata_i[15:0]}};
                rdata_fmt_o = {{16{half_s[15]}}, half_s};
                misalign_o  = addr_lo_i[0];
            end
            F3_W: begin
                wstrb_o     = 4'b1111;
                rdata_fmt_o = rdata_i;
                misalign_o  = (addr_lo_i != 2'b00);
            end
            F3_BU: begin
                rdata_fmt_o = {24'h00_0000, byte_s};
                misalign_o  = is_store_i;
            end
            F3_HU: begin
                rdata_fmt_o = {16'h0000, half_s};
                misalign_o  = is_store_i | addr_lo_i[0];
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase

        // Loads never drive byte enables
        if (!is_store_i) begin
            wstrb_o = 4'b0000;
        end else begin
            wstrb_o = wstrb_o;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a req/ack bus, stalls upstream while pending,
// times out a silent bus and registers the result into MEM/WB.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] WriteData_in,
    input  logic [2:0]  funct3_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUresult_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [4:0]  rd_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        valid_q,    valid_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [31:0] alu_q,      alu_d;
    logic        regwr_q,    regwr_d;
    logic        m2r_q,      m2r_d;
    logic [4:0]  rd_q,       rd_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q,  bus_err_d;

    logic        memop_s, fault_s, good_s, misalign_s;
    logic        timeout_hit_s, retire_s, bus_err_s, load_ok_s;
    logic [31:0] rdata_fmt_s;

    lsu_align u_align (
        .addr_lo_i   (ALUresult_in[1:0]),
        .funct3_i    (funct3_in),
        .is_store_i  (MemWrite_in),
        .wdata_i     (WriteData_in),
        .rdata_i     (dmem_rdata),
        .wstrb_o     (dmem_wstrb),
        .wdata_sh_o  (dmem_wdata),
        .rdata_fmt_o (rdata_fmt_s),
        .misalign_o  (misalign_s)
    );

    assign memop_s       = valid_in & (MemRead_in | MemWrite_in);
    assign fault_s       = memop_s & misalign_s;
    assign good_s        = memop_s & ~misalign_s;
    assign timeout_hit_s = (state_q == BUSY) && (cnt_q == TIMEOUT_C);
    // Reset gates the request so an in-flight access is abandoned immediately
    assign dmem_req      = reset_n & ((state_q == BUSY) | good_s);
    assign dmem_we       = MemWrite_in;
    assign dmem_addr     = {ALUresult_in[31:2], 2'b00};
    assign stall_out     = dmem_req & ~dmem_ack & ~timeout_hit_s;
    assign retire_s      = ~stall_out;
    assign bus_err_s     = timeout_hit_s & ~dmem_ack;
    assign load_ok_s     = MemRead_in & good_s & dmem_req & dmem_ack;

    // FSM next-state and timeout counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (good_s && !dmem_ack) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(0);
                end
            end
            BUSY: begin
                if (dmem_ack || timeout_hit_s) begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(0);
                end else begin
                    state_d = BUSY;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    // MEM/WB next values: faults and valid pulse only on a retire edge
    always_comb begin
        valid_d    = 1'b0;
        regwr_d    = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        rdata_d    = rdata_q;
        alu_d      = alu_q;
        m2r_d      = m2r_q;
        rd_d       = rd_q;
        if (retire_s) begin
            valid_d    = valid_in;
            alu_d      = ALUresult_in;
            m2r_d      = MemToReg_in;
            rd_d       = rd_in;
            misalign_d = fault_s;
            bus_err_d  = bus_err_s;
            regwr_d    = valid_in & RegWrite_in & ~fault_s & ~bus_err_s;
            rdata_d    = load_ok_s ? rdata_fmt_s : 32'h0000_0000;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_W'(0);
            valid_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            alu_q      <= 32'h0000_0000;
            regwr_q    <= 1'b0;
            m2r_q      <= 1'b0;
            rd_q       <= 5'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            regwr_q    <= regwr_d;
            m2r_q      <= m2r_d;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign valid_out     = valid_q;
    assign ReadData_out  = rdata_q;
    assign ALUresult_out = alu_q;
    assign RegWrite_out  = regwr_q;
    assign MemToReg_out  = m2r_q;
    assign rd_out        = rd_q;
    assign misalign_out  = misalign_q;
    assign bus_err_out   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short bus timeout (4 cycles).
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [31:0] ALUresult_in;
    logic [31:0] WriteData_in;
    logic [2:0]  funct3_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, dmem_ack, stall_out;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        valid_out, RegWrite_out, MemToReg_out, misalign_out, bus_err_out;
    logic [31:0] ReadData_out, ALUresult_out;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
        .ALUresult_in(ALUresult_in), .WriteData_in(WriteData_in), .funct3_in(funct3_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .valid_out(valid_out),
        .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .rd_out(rd_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Inputs change at edge+1, combinational checks at edge+2
    task automatic drive(input logic v, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic rd_en, input logic wr_en,
                         input logic rw, input logic [4:0] rd, input logic ack,
                         input logic [31:0] rdata);
        valid_in = v; ALUresult_in = addr; WriteData_in = wd; funct3_in = f3;
        MemRead_in = rd_en; MemWrite_in = wr_en; RegWrite_in = rw; MemToReg_in = rd_en;
        rd_in = rd; dmem_ack = ack; dmem_rdata = rdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        tick(); tick();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_rdata", ReadData_out, 32'h0);
        chk("rst_regwr", {31'd0, RegWrite_out}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        reset_n = 1'b1;

        // LW 0x100, ack in request cycle
        drive(1'b1, 32'h0000_0100, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF);
        chk("lw_req", {31'd0, dmem_req}, 32'd1);
        chk("lw_stall", {31'd0, stall_out}, 32'd0);
        chk("lw_addr", dmem_addr, 32'h0000_0100);
        chk("lw_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        tick();
        chk("lw_valid", {31'd0, valid_out}, 32'd1);
        chk("lw_rdata", ReadData_out, 32'hDEAD_BEEF);
        chk("lw_regwr", {31'd0, RegWrite_out}, 32'd1);
        chk("lw_rd", {27'd0, rd_out}, 32'd7);
        chk("lw_alu", ALUresult_out, 32'h0000_0100);

        // LB 0x103, ack after three stalled cycles
        drive(1'b1, 32'h0000_0103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 32'h80FF_FF7F);
        chk("lb_stall0", {31'd0, stall_out}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h0000_0100);
        tick();
        chk("lb_stall1", {31'd0, stall_out}, 32'd1);
        chk("lb_novalid", {31'd0, valid_out}, 32'd0);
        chk("lb_noregwr", {31'd0, RegWrite_out}, 32'd0);
        tick();
        chk("lb_stall2", {31'd0, stall_out}, 32'd1);
        tick();
        dmem_ack = 1'b1; #1;
        chk("lb_ack_nostall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("lb_rdata", ReadData_out, 32'hFFFF_FF80);
        chk("lb_valid", {31'd0, valid_out}, 32'd1);
        chk("lb_regwr", {31'd0, RegWrite_out}, 32'd1);

        drive(1'b1, 32'h0000_0103, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 32'h80FF_FF7F);
        tick();
        chk("lbu_rdata", ReadData_out, 32'h0000_0080);

        drive(1'b1, 32'h0000_0106, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h8001_1234);
        tick();
        chk("lh_rdata", ReadData_out, 32'hFFFF_8001);
        drive(1'b1, 32'h0000_0106, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h8001_1234);
        tick();
        chk("lhu_rdata", ReadData_out, 32'h0000_8001);

        // SH 0x202
        drive(1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0);
        chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, dmem_we}, 32'd1);
        chk("sh_addr", dmem_addr, 32'h0000_0200);
        tick();
        chk("sh_regwr", {31'd0, RegWrite_out}, 32'd0);
        chk("sh_valid", {31'd0, valid_out}, 32'd1);

        drive(1'b1, 32'h0000_0301, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0);
        chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        drive(1'b1, 32'h0000_0300, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0);
        chk("sw_wstrb", {28'd0, dmem_wstrb}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'h1122_3344);
        tick();

        // Misaligned LW, then illegal store encoding
        drive(1'b1, 32'h0000_0101, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0);
        chk("mis_noreq", {31'd0, dmem_req}, 32'd0);
        chk("mis_nostall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("mis_flag", {31'd0, misalign_out}, 32'd1);
        chk("mis_regwr", {31'd0, RegWrite_out}, 32'd0);
        chk("mis_valid", {31'd0, valid_out}, 32'd1);
        chk("mis_rdata", ReadData_out, 32'h0);
        drive(1'b1, 32'h0000_0100, 32'h0, 3'b100, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("sbu_noreq", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("sbu_flag", {31'd0, misalign_out}, 32'd1);
        idle();
        tick();
        chk("mis_pulse", {31'd0, misalign_out}, 32'd0);
        chk("idle_valid", {31'd0, valid_out}, 32'd0);

        // Timeout: no ack, 4 stall cycles then bus error
        drive(1'b1, 32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stall%0d", i), {31'd0, stall_out}, 32'd1);
            tick();
        end
        chk("to_release", {31'd0, stall_out}, 32'd0);
        chk("to_req_held", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("to_buserr", {31'd0, bus_err_out}, 32'd1);
        chk("to_valid", {31'd0, valid_out}, 32'd1);
        chk("to_regwr", {31'd0, RegWrite_out}, 32'd0);
        chk("to_rdata", ReadData_out, 32'h0);
        idle();
        tick();
        chk("to_pulse", {31'd0, bus_err_out}, 32'd0);

        // Reset during BUSY, then a late ack
        drive(1'b1, 32'h0000_0500, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 32'h0);
        tick();
        chk("rb_busy_stall", {31'd0, stall_out}, 32'd1);
        reset_n = 1'b0; #1;
        chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rb_stall_drop", {31'd0, stall_out}, 32'd0);
        tick();
        chk("rb_alu", ALUresult_out, 32'h0);
        chk("rb_valid", {31'd0, valid_out}, 32'd0);
        reset_n = 1'b1;
        drive(1'b0, 32'h0000_0500, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1234_5678);
        chk("rb_late_noreq", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("rb_late_valid", {31'd0, valid_out}, 32'd0);
        chk("rb_late_regwr", {31'd0, RegWrite_out}, 32'd0);
        chk("rb_late_rdata", ReadData_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
